// File: rtl/pn_stack_eval_if.sv
// Token/result channel of the Polish Notation evaluator.
// The master side is the token source and result sink; the slave side is the evaluator.
interface pn_stack_eval_if #(
    parameter int IN_W  = 3,
    parameter int OUT_W = 32
);
    logic             mode;
    logic             operator;
    logic [IN_W-1:0]  in;
    logic             in_valid;
    logic             in_ready;
    logic             out_valid;
    logic [OUT_W-1:0] out;
    logic             err;

    modport master (
        output mode, operator, in, in_valid,
        input  in_ready, out_valid, out, err
    );

    modport slave (
        input  mode, operator, in, in_valid,
        output in_ready, out_valid, out, err
    );
endinterface

// File: rtl/pn_stack_eval.sv
// Polish Notation evaluator: buffers one burst of tokens, then runs a stack machine
// one token per cycle in prefix or postfix order, flagging malformed expressions.
module pn_stack_eval #(
    parameter int IN_W    = 3,
    parameter int OUT_W   = 32,
    parameter int MAX_TOK = 16,
    parameter int STK_D   = 9
) (
    input logic           clk,
    input logic           rst_n,
    pn_stack_eval_if.slave bus
);
    localparam int CNT_W = $clog2(MAX_TOK + 1);
    localparam int IDX_W = (MAX_TOK > 1) ? $clog2(MAX_TOK) : 1;
    localparam int SP_W  = $clog2(STK_D + 1);
    localparam int SI_W  = (STK_D > 1) ? $clog2(STK_D) : 1;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EVAL, S_DONE} state_t;
    typedef enum logic [2:0] {
        OP_ADD = 3'd0, OP_SUB = 3'd1, OP_MUL = 3'd2,
        OP_ABSDIFF = 3'd3, OP_MAX = 3'd4, OP_MIN = 3'd5
    } opcode_t;

    state_t           state;
    logic             mode_r;
    logic             ovf_tok;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx;
    logic [SP_W-1:0]  sp;

    logic                    tok_op  [MAX_TOK];
    logic [IN_W-1:0]         tok_val [MAX_TOK];
    logic signed [OUT_W-1:0] stack   [STK_D];

    // Token capture
    logic             tok_we;
    logic [IDX_W-1:0] tok_wi;
    logic             buf_full;

    assign buf_full = (cnt == CNT_W'(MAX_TOK));
    assign tok_we   = bus.in_valid &&
                      ((state == S_IDLE) || (state == S_LOAD && !buf_full));
    assign tok_wi   = (state == S_IDLE) ? '0 : IDX_W'(cnt);

    // The first evaluation step shares the edge that closes the burst, so an
    // n-token expression finishes n edges after its last token.
    logic             step;
    logic [IDX_W-1:0] cur_idx;
    logic             last_tok;
    logic             cur_op;
    logic [IN_W-1:0]  cur_val;

    assign step     = (state == S_EVAL) || (state == S_LOAD && !bus.in_valid);
    assign cur_idx  = (state == S_LOAD) ? (mode_r ? '0 : IDX_W'(cnt - 1'b1)) : idx;
    assign last_tok = mode_r ? (cur_idx == IDX_W'(cnt - 1'b1)) : (cur_idx == '0);
    assign cur_op   = tok_op[cur_idx];
    assign cur_val  = tok_val[cur_idx];

    // Operand order depends on scan direction: prefix takes op1 from the top.
    logic signed [OUT_W-1:0] top, nxt, op1, op2, alu_res;
    logic                    op_legal;

    assign top = stack[SI_W'(sp - 1'b1)];
    assign nxt = stack[SI_W'(sp - 2'd2)];
    assign op1 = mode_r ? nxt : top;
    assign op2 = mode_r ? top : nxt;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        alu_res  = '0;
        op_legal = 1'b1;
        case (opcode_t'(cur_val[2:0]))
            OP_ADD:     alu_res = op1 + op2;
            OP_SUB:     alu_res = op1 - op2;
            OP_MUL:     alu_res = op1 * op2;
            OP_ABSDIFF: alu_res = (op1 >= op2) ? op1 - op2 : op2 - op1;
            OP_MAX:     alu_res = (op1 >= op2) ? op1 : op2;
            OP_MIN:     alu_res = (op1 <= op2) ? op1 : op2;
            default:    op_legal = 1'b0;
        endcase
    end

    // Stack update and error detection for the token under evaluation
    logic                    wr_en;
    logic [SI_W-1:0]         wr_idx;
    logic signed [OUT_W-1:0] wr_data;
    logic [SP_W-1:0]         sp_nxt;
    logic                    step_err;
    logic signed [OUT_W-1:0] result;
    logic                    done_step;

    always_comb begin
        // NOTE: blocking assignments in combinational logic; state registers use <= only.
        wr_en    = 1'b0;
        wr_idx   = '0;
        wr_data  = '0;
        sp_nxt   = sp;
        step_err = ovf_tok;
        if (!cur_op) begin
            if (sp == SP_W'(STK_D)) begin
                step_err = 1'b1;
            end else begin
                wr_en   = 1'b1;
                wr_idx  = SI_W'(sp);
                wr_data = OUT_W'(cur_val);
                sp_nxt  = sp + 1'b1;
            end
        end else if (sp < SP_W'(2) || !op_legal) begin
            step_err = 1'b1;
        end else begin
            wr_en   = 1'b1;
            wr_idx  = SI_W'(sp - 2'd2);
            wr_data = alu_res;
            sp_nxt  = sp - 1'b1;
        end
        if (last_tok && sp_nxt != SP_W'(1)) begin
            step_err = 1'b1;
        end
    end

    assign result    = (wr_en && wr_idx == '0) ? wr_data : stack[0];
    assign done_step = step && (step_err || last_tok);

    // NOTE: token buffer and stack carry no reset; cnt and sp gate every read.
    always_ff @(posedge clk) begin
        if (tok_we) begin
            tok_op[tok_wi]  <= bus.operator;
            tok_val[tok_wi] <= bus.in;
        end
        if (step && wr_en) begin
            stack[wr_idx] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            mode_r        <= 1'b0;
            ovf_tok       <= 1'b0;
            cnt           <= '0;
            idx           <= '0;
            sp            <= '0;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.out       <= '0;
            bus.err       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        mode_r  <= bus.mode;
                        ovf_tok <= 1'b0;
                        cnt     <= CNT_W'(1);
                        state   <= S_LOAD;
                    end
                end
                S_LOAD, S_EVAL: begin
                    if (step) begin
                        idx          <= mode_r ? cur_idx + 1'b1 : cur_idx - 1'b1;
                        sp           <= sp_nxt;
                        bus.in_ready <= 1'b0;
                        if (done_step) begin
                            state         <= S_DONE;
                            bus.out_valid <= 1'b1;
                            bus.err       <= step_err;
                            bus.out       <= step_err ? '0 : result;
                        end else begin
                            state <= S_EVAL;
                        end
                    end else if (buf_full) begin
                        ovf_tok <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    state         <= S_IDLE;
                    bus.in_ready  <= 1'b1;
                    bus.out_valid <= 1'b0;
                    bus.out       <= '0;
                    bus.err       <= 1'b0;
                    sp            <= '0;
                    cnt           <= '0;
                    idx           <= '0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pn_stack_eval.sv
// Randomised scoreboard bench for pn_stack_eval against a queue-based reference evaluator.
module tb_pn_stack_eval;
    localparam int IN_W    = 3;
    localparam int OUT_W   = 32;
    localparam int MAX_TOK = 16;
    localparam int STK_D   = 9;

    typedef struct packed {
        logic       op;
        logic [2:0] val;
    } tok_t;

    typedef struct {
        logic [31:0] out;
        logic        err;
        int          steps;
        int          due;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;
    int   ec    = 0;
    exp_t sb[$];
    exp_t mon_e;

    always #5 clk = ~clk;
    always @(posedge clk) ec <= ec + 1;

    pn_stack_eval_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

    pn_stack_eval #(
        .IN_W(IN_W), .OUT_W(OUT_W), .MAX_TOK(MAX_TOK), .STK_D(STK_D)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus.slave)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic tok_t num(input int v);
        return {1'b0, 3'(v)};
    endfunction

    function automatic tok_t opr(input int c);
        return {1'b1, 3'(c)};
    endfunction

    // Reference: evaluate the token list directly from the language rules.
    function automatic exp_t model(input bit pf, input tok_t toks[$]);
        logic signed [31:0] st[$];
        logic signed [31:0] a, b, op1, op2, r;
        exp_t e;
        int n;
        tok_t t;
        n = toks.size();
        e.out = '0; e.err = 1'b0; e.steps = 0; e.due = 0;
        if (n > MAX_TOK) begin
            e.err = 1'b1; e.steps = 1;
            return e;
        end
        for (int s = 0; s < n; s++) begin
            t = toks[pf ? s : n - 1 - s];
            e.steps = s + 1;
            if (!t.op) begin
                if (st.size() == STK_D) begin e.err = 1'b1; return e; end
                st.push_back(32'(t.val));
            end else begin
                if (st.size() < 2 || t.val > 3'd5) begin e.err = 1'b1; return e; end
                a = st.pop_back();
                b = st.pop_back();
                op1 = pf ? b : a;
                op2 = pf ? a : b;
                case (t.val)
                    3'd0:    r = op1 + op2;
                    3'd1:    r = op1 - op2;
                    3'd2:    r = op1 * op2;
                    3'd3:    r = (op1 > op2) ? op1 - op2 : op2 - op1;
                    3'd4:    r = (op1 > op2) ? op1 : op2;
                    default: r = (op1 < op2) ? op1 : op2;
                endcase
                st.push_back(r);
            end
        end
        if (st.size() != 1) e.err = 1'b1;
        else e.out = st[0];
        return e;
    endfunction

    // Monitor: every strobe pops one expectation; quiet cycles must show zeros.
    always @(negedge clk) begin
        if (bus.out_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_out_valid", 64'(bus.out_valid), 64'd0);
            end else begin
                mon_e = sb.pop_front();
                check("result", 64'(bus.out), 64'(mon_e.out));
                check("err", 64'(bus.err), 64'(mon_e.err));
                check("latency_edge", 64'(ec), 64'(mon_e.due));
            end
        end else begin
            check("idle_out_zero", {31'd0, bus.err, bus.out}, 64'd0);
        end
    end

    task automatic send(input bit pf, input tok_t toks[$]);
        exp_t e;
        int guard;
        guard = 0;
        while (!bus.in_ready && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!bus.in_ready) begin
            check("in_ready_timeout", 64'(bus.in_ready), 64'd1);
            return;
        end
        e = model(pf, toks);
        for (int i = 0; i < toks.size(); i++) begin
            bus.mode     = (i == 0) ? pf : 1'($urandom);
            bus.operator = toks[i].op;
            bus.in       = toks[i].val;
            bus.in_valid = 1'b1;
            @(posedge clk); #1;
        end
        e.due = ec + e.steps;
        sb.push_back(e);
        bus.in_valid = 1'b0;
        bus.in       = 3'($urandom);
        @(posedge clk); #1;
        guard = 0;
        // Junk strobes while busy must be ignored.
        while (!bus.in_ready && guard < 200) begin
            bus.in_valid = 1'($urandom);
            bus.operator = 1'($urandom);
            bus.in       = 3'($urandom);
            @(posedge clk); #1;
            guard++;
        end
        bus.in_valid = 1'b0;
        if (!bus.in_ready) check("busy_timeout", 64'(bus.in_ready), 64'd1);
    endtask

    task automatic gen_expr(output bit pf, output tok_t q[$]);
        tok_t r[$];
        int depth, target, p;
        q.delete();
        pf     = 1'($urandom_range(0, 1));
        depth  = 0;
        target = $urandom_range(1, MAX_TOK - 1);
        while (q.size() < target) begin
            if (depth < 2 || (depth < STK_D && $urandom_range(0, 1) == 1)) begin
                q.push_back(num($urandom_range(0, 7)));
                depth++;
            end else begin
                q.push_back(opr($urandom_range(0, 5)));
                depth--;
            end
        end
        while (depth > 1 && q.size() < MAX_TOK) begin
            q.push_back(opr($urandom_range(0, 5)));
            depth--;
        end
        if ($urandom_range(0, 4) == 0) begin
            p = $urandom_range(0, q.size() - 1);
            q[p] = {1'($urandom), 3'($urandom)};
        end
        if (!pf) begin
            for (int i = q.size() - 1; i >= 0; i--) r.push_back(q[i]);
            q = r;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        tok_t tq[$];
        bit   pf;
        int   guard;
        bus.mode = 1'b0; bus.operator = 1'b0; bus.in = '0; bus.in_valid = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out", 64'(bus.out), 64'd0);
        check("rst_err", 64'(bus.err), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        tq = '{num(3), num(4), opr(0), num(2), opr(2)};            send(1'b1, tq);
        tq = '{opr(1), num(2), num(5)};                            send(1'b0, tq);
        tq = '{opr(4), num(7), opr(3), num(1), num(6)};            send(1'b0, tq);
        tq = '{num(7), num(7), opr(2), num(7), opr(2)};            send(1'b1, tq);
        tq = '{num(5), opr(0)};                                    send(1'b1, tq);
        tq = '{num(1), num(2)};                                    send(1'b1, tq);
        tq = '{num(1), num(2), opr(7)};                            send(1'b1, tq);
        tq.delete();
        for (int i = 0; i < MAX_TOK + 1; i++) tq.push_back(num(i % 8));
        send(1'b1, tq);
        tq = '{num(1), num(1), opr(0)};                            send(1'b1, tq);
        tq = '{num(6)};                                            send(1'b0, tq);
        tq.delete();
        for (int i = 0; i < STK_D + 1; i++) tq.push_back(num(1));
        send(1'b1, tq);
        tq = '{num(0), num(5), opr(1), num(3), opr(5)};            send(1'b1, tq);

        // Abort mid-evaluation: no result may ever appear for this burst.
        for (int i = 0; i < 12; i++) begin
            bus.mode = 1'b1; bus.operator = 1'b0; bus.in = 3'd2; bus.in_valid = 1'b1;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", 64'(bus.out_valid), 64'd0);
        check("abort_out", 64'(bus.out), 64'd0);
        check("abort_err", 64'(bus.err), 64'd0);
        check("abort_in_ready", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;

        for (int r = 0; r < 60; r++) begin
            gen_expr(pf, tq);
            send(pf, tq);
        end

        guard = 0;
        while (sb.size() > 0 && guard < 1000) begin
            @(posedge clk);
            guard++;
        end
        if (sb.size() > 0) check("drain_pending", 64'(sb.size()), 64'd0);
        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
